// File: rtl/sensor_scanner_if.sv
// Shared request/acknowledge bus between the scanner and the four altitude sensors.
// The scanner is the master: it selects a sensor and requests; the sensor side acks with data.
interface sensor_scanner_if;
  logic [1:0] sens_sel;
  logic       sens_req;
  logic       sens_ack;
  logic [7:0] sens_data;

  modport master (output sens_sel, sens_req, input  sens_ack, sens_data);
  modport slave  (input  sens_sel, sens_req, output sens_ack, sens_data);
endinterface

// File: rtl/sensor_scanner.sv
// Polls four altitude sensors in turn and publishes all readings together on DONE entry.
// A sensor that stays silent for TIMEOUT REQ cycles reads as 0 with its fault bit set.

// One lane per sensor: a shadow reading/fault captured during the scan, and a published copy.
module sensor_scanner_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cap,
  input  logic             cap_flt,
  input  logic             commit,
  input  logic [VEC_W-1:0] cap_data,
  output logic [VEC_W-1:0] rd,
  output logic             flt
);
  logic [VEC_W-1:0] shadow_q, shadow_d, rd_q, rd_d;
  logic             sflt_q, sflt_d, flt_q, flt_d;

  always_comb begin
    shadow_d = cap ? cap_data : shadow_q;
    sflt_d   = cap ? cap_flt : (clr ? 1'b0 : sflt_q);
    rd_d     = commit ? shadow_q : rd_q;
    flt_d    = commit ? sflt_q : flt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      sflt_q   <= 1'b0;
      rd_q     <= '0;
      flt_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      sflt_q   <= sflt_d;
      rd_q     <= rd_d;
      flt_q    <= flt_d;
    end
  end

  assign rd  = rd_q;
  assign flt = flt_q;
endmodule

module sensor_scanner #(
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  sensor_scanner_if.master        bus,
  output logic [7:0]              sensor1,
  output logic [7:0]              sensor2,
  output logic [7:0]              sensor3,
  output logic [7:0]              sensor4,
  output logic [3:0]              fault,
  output logic                    valid,
  output logic                    busy
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  logic                            hit, tmo, clr, commit;
  logic [VEC_W-1:0]                cap_data;
  logic [NUM_LANES-1:0]            cap;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd;
  logic [NUM_LANES-1:0]            flt;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    // Ack beats timeout when both land on the same edge.
    hit      = (state_q == REQ) && bus.sens_ack;
    tmo      = (state_q == REQ) && !bus.sens_ack && (cnt_q == TMO_LAST);
    clr      = (state_q == IDLE) && start;
    commit   = (state_q == GAP) && (sel_q == 2'd3);
    cap_data = bus.sens_ack ? bus.sens_data : '0;

    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        sel_d   = 2'd0;
        cnt_d   = 8'd0;
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (hit || tmo) state_d = GAP;
      end
      GAP: if (sel_q == 2'd3) begin
        state_d = DONE;
      end else begin
        sel_d   = sel_q + 2'd1;
        cnt_d   = 8'd0;
        state_d = REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_d   = (state_d == REQ);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);

    for (int i = 0; i < NUM_LANES; i++)
      cap[i] = (hit || tmo) && (sel_q == 2'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sensor_scanner_lane #(.VEC_W(VEC_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .cap      (cap[g]),
      .cap_flt  (tmo),
      .commit   (commit),
      .cap_data (cap_data),
      .rd       (rd[g]),
      .flt      (flt[g])
    );
  end

  assign bus.sens_sel = sel_q;
  assign bus.sens_req = req_q;
  assign sensor1      = rd[0];
  assign sensor2      = rd[1];
  assign sensor3      = rd[2];
  assign sensor4      = rd[3];
  assign fault        = flt;
  assign valid        = valid_q;
  assign busy         = busy_q;
endmodule
